instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the decode/control unit. Holds the PC, issues word reads to a fixed-latency instruction memory, buffers returned instructions in a 2-entry queue, and presents them to decode with a valid/ready handshake. `if_opcode` drives the control unit's opcode input. Branch redirects from EX flush all in-flight and buffered wrong-path instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `ADDR_W`, default 32: PC/address width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: read request this cycle.
- `imem_addr` output ADDR_W: word-aligned read address (registered PC).
- `imem_rdata` input 32: instruction; valid exactly one cycle after an `imem_req` cycle.
- `redirect_valid` input 1: branch taken; load new PC.
- `redirect_pc` input ADDR_W: target; bits [1:0] ignored, forced to 0.
- `if_valid` output 1: instruction available to decode.
- `if_ready` input 1: decode accepts this cycle.
- `if_instr` output 32: instruction at queue head.
- `if_pc` output ADDR_W: PC of `if_instr`.
- `if_opcode` output 7: `if_instr[6:0]`, to control unit.

## Operation
- State: `pc_q`, `inflight` flag + `inflight_pc`, 2-entry queue {pc, instr} with count 0..2.
- Pop = `if_valid && if_ready`. Issue = `!redirect_valid && (count + inflight - pop) < 2`; `imem_req` = issue, `imem_addr` = `pc_q`; on issue `pc_q <= pc_q + 4` (wraps modulo 2^ADDR_W), `inflight <= 1`, `inflight_pc <= pc_q`; else `inflight <= 0`.
- Response cycle (`inflight`=1): push {`inflight_pc`, `imem_rdata`} unless killed. Push and pop in the same cycle allowed at count 1 or 2; the issue rule guarantees no push when full without pop.
- Redirect (cycle T): `pc_q <= {redirect_pc[ADDR_W-1:2],2'b00}`; queue count cleared; in-flight response arriving T+1 discarded; no request in T; `if_valid` forced 0 in T (combinational mask, the head is wrong-path). Redirect in consecutive cycles: last one wins.
- `if_valid` = (count != 0) && !redirect_valid. When count = 0, `if_instr` = 32'h0000_0013 (NOP), `if_pc` = last head value.
- No decode of instruction content; no exceptions on fetch.

## Timing
- Reset values: `imem_req` 0, `imem_addr` RESET_PC, `if_valid` 0, `if_instr` 32'h0000_0013, `if_pc` RESET_PC, `if_opcode` 7'b0010011; count 0, `inflight` 0. `imem_req` held 0 while `rst_n` low.
- First request in the first cycle after `rst_n` rises (C0); `if_valid` first high at C2.
- Request-to-`if_valid` latency: 2 cycles. Redirect-to-`if_valid`: 3 cycles (T redirect, T+1 request, T+3 valid).
- Steady state with `if_ready` high: one instruction per cycle, consecutive PCs.
- Back-pressure: with `if_ready` low, at most 2 instructions buffered, `imem_req` drops once count + inflight = 2; no instruction lost or duplicated.
- Reset asserted mid-operation: all state cleared immediately; pending response ignored.

## Structure
- Shared package `rv_pkg`: `XLEN`, `NOP_INSTR` (32'h0000_0013), opcode constants (`OP_R`, `OP_LOAD`, `OP_IMM`, `OP_STORE`, `OP_BRANCH`) shared with the control unit.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO with push/pop/flush, count output, async active-low reset. Top holds PC, issue logic, kill logic.

## Test plan
- Reset release, `if_ready`=1, imem returns `addr` as data -> `imem_addr` 0,4,8,… from C0; `if_valid` from C2, `if_pc`=0,4,8 one per cycle, `if_instr`=`if_pc`.
- `if_ready` low 5 cycles from steady state -> exactly 2 entries held, `imem_req` low after fill; on release PCs continue with no gap or repeat.
- Redirect to 32'h100 while queue full and one in flight -> `if_valid` 0 at T, T+1, T+2; next delivered `if_pc`=32'h100, then 32'h104; no wrong-path PC ever delivered.
- `redirect_pc`=32'h0000_0203 -> `imem_addr`=32'h0000_0200.
- PC near top: redirect to 32'hFFFF_FFFC -> following fetch address 32'h0000_0000.
- Assert `rst_n` low mid-stream with `inflight`=1 -> outputs at reset values same cycle; after release fetch restarts at RESET_PC, stale data not delivered.

Source files
------------

// File: rtl/rv_pkg.sv
// Constants shared between the fetch stage and the control unit.
package rv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode.
module fetch_queue #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_instr,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_instr,
  output logic [1:0]        count
);

  logic [ADDR_W-1:0] pc_q    [2];
  logic [31:0]       instr_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Flush wins over a same-cycle push; the upstream kill logic relies on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]    <= push_pc;
        instr_q[wr_ptr_q] <= push_instr;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_pc    = pc_q[rd_ptr_q];
  assign head_instr = instr_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, fixed-latency imem requests, 2-entry buffer, redirect flush.
module instr_fetch
  import rv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = XLEN,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [6:0]        if_opcode
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, last_pc_q, head_pc;
  logic              inflight_q;
  logic [31:0]       head_instr;
  logic [1:0]        count;
  logic              head_valid, pop, push, issue;
  logic [2:0]        occupancy;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    head_valid = (count != 2'd0);
    // The head is wrong-path during a redirect cycle, so hide it from decode.
    if_valid   = head_valid && !redirect_valid;
    pop        = if_valid && if_ready;
    push       = inflight_q && !redirect_valid;
    occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = rst_n && !redirect_valid && (occupancy < 3'd2);
    pc_d       = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      last_pc_q     <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
      if (head_valid) begin
        last_pc_q <= head_pc;
      end
    end
  end

  fetch_queue #(
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (inflight_pc_q),
    .push_instr (imem_rdata),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign if_instr  = head_valid ? head_instr : NOP_INSTR;
  assign if_pc     = head_valid ? head_pc : last_pc_q;
  assign if_opcode = if_instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; imem returns the requested address as data.
module tb_instr_fetch;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;

  int errors = 0;
  int checks = 0;

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode)
  );

  always #5 clk = ~clk;

  // One-cycle memory; garbage when no request so stale data is recognisable.
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    32'(imem_req),  32'd0);
    chk({tag, "_addr"},   imem_addr,      32'h0);
    chk({tag, "_valid"},  32'(if_valid),  32'd0);
    chk({tag, "_instr"},  if_instr,       NOP_INSTR);
    chk({tag, "_pc"},     if_pc,          32'h0);
    chk({tag, "_opcode"}, 32'(if_opcode), 32'(OP_IMM));
  endtask

  task automatic chk_deliver(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"},    if_pc,         pc);
    chk({tag, "_instr"}, if_instr,      pc);
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset values.
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming from reset, C0..C7.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stream_req",  32'(imem_req), 32'd1);
      chk("stream_addr", imem_addr,     32'(4 * k));
      if (k < 2) chk("stream_valid_early", 32'(if_valid), 32'd0);
      else       chk_deliver("stream", 32'(4 * (k - 2)));
      next_cycle();
    end

    // Back-pressure C8..C12: head 24 held, one more (28) buffered, requests stop.
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_req",  32'(imem_req), 32'd0);
      chk("bp_addr", imem_addr,     32'h20);
      chk_deliver("bp_hold", 32'h18);
      next_cycle();
    end

    // Release C13..C17: 24,28,32,36,40 with no gap or repeat.
    if_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_deliver("bp_release", 32'(24 + 4 * k));
      next_cycle();
    end

    // Redirect at T with head 44 queued and 48 in flight.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("redir_T_valid", 32'(if_valid), 32'd0);
    chk("redir_T_req",   32'(imem_req), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_T1_valid", 32'(if_valid), 32'd0);
    chk("redir_T1_req",   32'(imem_req), 32'd1);
    chk("redir_T1_addr",  imem_addr,     32'h100);
    chk("redir_T1_instr", if_instr,      NOP_INSTR);
    chk("redir_T1_pc",    if_pc,         32'h2C);
    next_cycle();
    @(negedge clk);
    chk("redir_T2_valid", 32'(if_valid), 32'd0);
    chk("redir_T2_addr",  imem_addr,     32'h104);
    next_cycle();
    @(negedge clk);
    chk_deliver("redir_T3", 32'h100);
    next_cycle();
    @(negedge clk);
    chk_deliver("redir_T4", 32'h104);
    next_cycle();

    // Back-to-back redirects: 0x203 then 0xFFFF_FFFC, last one wins, PC wraps.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    chk("rr0_valid", 32'(if_valid), 32'd0);
    next_cycle();
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("rr1_align_addr", imem_addr,     32'h200);
    chk("rr1_req",        32'(imem_req), 32'd0);
    chk("rr1_valid",      32'(if_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr_top", imem_addr,     32'hFFFF_FFFC);
    chk("wrap_req",      32'(imem_req), 32'd1);
    chk("wrap_valid0",   32'(if_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("wrap_addr_zero", imem_addr,     32'h0);
    chk("wrap_valid1",    32'(if_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk_deliver("wrap_top", 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk_deliver("wrap_zero", 32'h0);
    next_cycle();

    // Reset mid-stream with a response in flight; outputs clear immediately.
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_c0_req",   32'(imem_req), 32'd1);
    chk("rst2_c0_addr",  imem_addr,     32'h0);
    chk("rst2_c0_valid", 32'(if_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst2_c1_valid", 32'(if_valid), 32'd0);
    chk("rst2_c1_addr",  imem_addr,     32'h4);
    next_cycle();
    @(negedge clk);
    chk_deliver("rst2_c2", 32'h0);
    next_cycle();
    @(negedge clk);
    chk_deliver("rst2_c3", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
